// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable data width, parity and stop bits, fed by a
// word FIFO with a valid/ready handshake so queued frames leave back-to-back.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV    = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W = $clog2(DIV);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(DIV - 2);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // FIFO storage; the head word is read out through a register so the
  // array maps onto block RAM with a registered read port.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [DATA_BITS-1:0] head_data_reg;
  logic                 head_valid_reg;

  logic                 push;
  logic                 pop;
  logic                 refill;
  logic [CNT_W-1:0]     mem_words;

  state_t               state_reg;
  logic [BAUD_W-1:0]    baud_cnt_reg;
  logic [3:0]           bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_reg;
  logic                 txd_reg;
  logic                 busy_reg;
  logic                 tx_done_reg;

  logic                 bit_end;
  logic                 last_stop;

  assign s_ready    = !reset && (count_reg < FULL_CNT);
  assign push       = s_valid && s_ready;
  assign mem_words  = count_reg - CNT_W'(head_valid_reg);
  assign refill     = !reset && (!head_valid_reg || pop) && (mem_words != '0);

  assign bit_end    = (baud_cnt_reg == BAUD_LAST);
  assign last_stop  = (bit_cnt_reg == STOP_LAST);

  assign txd        = txd_reg;
  assign busy       = busy_reg;
  assign tx_done    = tx_done_reg;
  assign fifo_count = count_reg;

  // The FSM takes the head word when idle, or at the very end of the last
  // stop bit so the next start bit follows with no idle gap.
  always_comb begin
    pop = 1'b0;
    case (state_reg)
      ST_IDLE: pop = head_valid_reg;
      ST_STOP: pop = head_valid_reg && bit_end && last_stop;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data;
    end
    if (refill) begin
      head_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (refill) begin
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
        head_valid_reg <= 1'b1;
      end else if (pop) begin
        head_valid_reg <= 1'b0;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          txd_reg      <= 1'b1;
          baud_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          if (pop) begin
            shift_reg  <= head_data_reg;
            parity_reg <= (PARITY == 1) ? ~^head_data_reg : ^head_data_reg;
            txd_reg    <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            txd_reg      <= shift_reg[0];
            shift_reg    <= shift_reg >> 1;
            state_reg    <= ST_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == DATA_LAST) begin
              bit_cnt_reg <= '0;
              if (PARITY != 0) begin
                txd_reg   <= parity_reg;
                state_reg <= ST_PARITY;
              end else begin
                txd_reg   <= 1'b1;
                state_reg <= ST_STOP;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              txd_reg     <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            txd_reg      <= 1'b1;
            state_reg    <= ST_STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        ST_STOP: begin
          // Raised one clock early so the pulse covers the final clock of the frame.
          tx_done_reg <= last_stop && (baud_cnt_reg == BAUD_PRE);
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (last_stop) begin
              bit_cnt_reg <= '0;
              if (pop) begin
                shift_reg  <= head_data_reg;
                parity_reg <= (PARITY == 1) ? ~^head_data_reg : ^head_data_reg;
                txd_reg    <= 1'b0;
                state_reg  <= ST_START;
              end else begin
                txd_reg   <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= ST_IDLE;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        default: begin
          txd_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 7N2) at DIV=10,
// checking line waveforms, tx_done timing, FIFO fill/order and mid-frame reset.
module tb_uart_tx_fifo;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       s_valid_v;
  logic [3:0][7:0]  s_data_v;

  logic s_ready0, s_ready1, s_ready2, s_ready3;
  logic txd0, txd1, txd2, txd3;
  logic busy0, busy1, busy2, busy3;
  logic done0, done1, done2, done3;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;

  logic [3:0]      ready_v, txd_v, busy_v, done_v;
  logic [3:0][2:0] cnt_v;

  assign ready_v = {s_ready3, s_ready2, s_ready1, s_ready0};
  assign txd_v   = {txd3, txd2, txd1, txd0};
  assign busy_v  = {busy3, busy2, busy1, busy0};
  assign done_v  = {done3, done2, done1, done0};
  assign cnt_v   = {cnt3, cnt2, cnt1, cnt0};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .reset(reset), .s_data(s_data_v[0]), .s_valid(s_valid_v[0]),
    .s_ready(s_ready0), .txd(txd0), .busy(busy0), .tx_done(done0), .fifo_count(cnt0));

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .reset(reset), .s_data(s_data_v[1]), .s_valid(s_valid_v[1]),
    .s_ready(s_ready1), .txd(txd1), .busy(busy1), .tx_done(done1), .fifo_count(cnt1));

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .reset(reset), .s_data(s_data_v[2]), .s_valid(s_valid_v[2]),
    .s_ready(s_ready2), .txd(txd2), .busy(busy2), .tx_done(done2), .fifo_count(cnt2));

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .reset(reset), .s_data(s_data_v[3][6:0]), .s_valid(s_valid_v[3]),
    .s_ready(s_ready3), .txd(txd3), .busy(busy3), .tx_done(done3), .fifo_count(cnt3));

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  // Frame decoder for the 8N1 instance, enabled only for the back-to-back test.
  logic       mon_en = 1'b0;
  logic       dec_active = 1'b0;
  int         dec_n = 0;
  logic [9:0] dec_line = '0;
  logic [9:0] rx_q[$];
  int         st_q[$];
  int         busy_gap = 0;
  int         mon_done = 0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (st_q.size() > 0 && rx_q.size() < 5 && busy_v[0] !== 1'b1) busy_gap++;
      if (done_v[0] === 1'b1) mon_done++;
      if (!dec_active && txd_v[0] === 1'b0) begin
        dec_active = 1'b1;
        dec_n = 0;
        st_q.push_back(cyc);
      end
      if (dec_active) begin
        if (dec_n % 10 == 5) dec_line[dec_n/10] = txd_v[0];
        dec_n++;
        if (dec_n == 100) begin
          dec_active = 1'b0;
          rx_q.push_back(dec_line);
        end
      end
    end
  end

  task automatic push_word(input int idx, input logic [7:0] data);
    @(negedge clk);
    s_valid_v[idx] = 1'b1;
    s_data_v[idx]  = data;
    check_eq("push_ready", 32'(ready_v[idx]), 32'd1);
    @(negedge clk);
    s_valid_v[idx] = 1'b0;
  endtask

  task automatic wait_start(input int idx, input int budget, output int waited);
    waited = 0;
    while (txd_v[idx] !== 1'b0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Starts on the negedge where the start bit is first seen; one pass per clock.
  task automatic capture_frame(input int idx, input int nbits, output logic [11:0] line,
                               output int glitches, output int done_pos, output int done_cnt,
                               output logic busy_last);
    logic first;
    line = '0; glitches = 0; done_pos = -1; done_cnt = 0; first = 1'b0; busy_last = 1'b0;
    for (int n = 0; n < nbits*10; n++) begin
      if (n > 0) @(negedge clk);
      if (n % 10 == 0) first = txd_v[idx];
      else if (txd_v[idx] !== first) glitches++;
      if (n % 10 == 5) line[n/10] = txd_v[idx];
      if (done_v[idx] === 1'b1) begin
        done_cnt++;
        done_pos = n;
      end
      busy_last = busy_v[idx];
    end
  endtask

  task automatic frame_test(input string name, input int idx, input logic [7:0] data,
                            input int nbits, input logic [11:0] exp_line);
    int waited, glitches, done_pos, done_cnt;
    logic [11:0] line;
    logic busy_last;
    push_word(idx, data);
    wait_start(idx, 20, waited);
    check_eq({name, "_latency"}, waited, 2);
    capture_frame(idx, nbits, line, glitches, done_pos, done_cnt, busy_last);
    check_eq({name, "_line"}, 32'(line), 32'(exp_line));
    check_eq({name, "_bit_timing"}, glitches, 0);
    check_eq({name, "_done_pos"}, done_pos, nbits*10 - 1);
    check_eq({name, "_done_cnt"}, done_cnt, 1);
    check_eq({name, "_busy_in_frame"}, 32'(busy_last), 32'd1);
    @(negedge clk);
    check_eq({name, "_busy_after"}, 32'(busy_v[idx]), 32'd0);
    check_eq({name, "_txd_after"}, 32'(txd_v[idx]), 32'd1);
  endtask

  initial begin
    logic [7:0] words[6];
    int hist[8];
    int acc, waited, bad;

    words = '{8'h3C, 8'hC3, 8'h5A, 8'h96, 8'h01, 8'hEE};
    reset = 1'b1;
    s_valid_v = '0;
    s_data_v = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", 32'(txd_v), 32'hF);
    check_eq("rst_busy", 32'(busy_v), 32'h0);
    check_eq("rst_done", 32'(done_v), 32'h0);
    check_eq("rst_ready", 32'(ready_v), 32'h0);
    check_eq("rst_count", 32'(cnt_v), 32'h0);
    reset = 1'b0;
    #1;
    check_eq("ready_after_rst", 32'(ready_v), 32'hF);

    frame_test("8n1_55", 0, 8'h55, 10, 12'h2AA);
    frame_test("8e1_07", 1, 8'h07, 11, 12'h60E);
    frame_test("8o1_07", 2, 8'h07, 11, 12'h40E);
    frame_test("7n2_7f", 3, 8'hFF, 10, 12'h3FE);

    // Fill test: s_valid held high while the FSM is idle.
    repeat (5) @(negedge clk);
    mon_en = 1'b1;
    s_valid_v[0] = 1'b1;
    s_data_v[0] = words[0];
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (ready_v[0] === 1'b1) acc++;
      @(negedge clk);
      hist[c] = int'(cnt_v[0]);
      s_data_v[0] = words[acc];
    end
    s_valid_v[0] = 1'b0;
    check_eq("fill_accepted", acc, 5);
    check_eq("fill_count_c1", hist[1], 2);
    check_eq("fill_pushpop_count", hist[2], 2);
    check_eq("fill_count_full", hist[7], 4);
    check_eq("fill_ready_full", 32'(ready_v[0]), 32'd0);
    repeat (510) @(negedge clk);
    mon_en = 1'b0;
    check_eq("b2b_frames", rx_q.size(), 5);
    for (int i = 0; i < rx_q.size() && i < 5; i++)
      check_eq($sformatf("b2b_frame%0d", i), 32'(rx_q[i]), 32'({1'b1, words[i], 1'b0}));
    for (int i = 1; i < st_q.size() && i < 5; i++)
      check_eq($sformatf("b2b_gap%0d", i), st_q[i] - st_q[i-1], 100);
    check_eq("b2b_done_cnt", mon_done, 5);
    check_eq("b2b_busy_gap", busy_gap, 0);
    check_eq("b2b_busy_end", 32'(busy_v[0]), 32'd0);
    check_eq("b2b_count_end", 32'(cnt_v[0]), 32'd0);

    // Mid-frame reset with two words queued.
    @(negedge clk);
    s_valid_v[0] = 1'b1;
    s_data_v[0] = 8'h11;
    @(negedge clk);
    s_data_v[0] = 8'h22;
    @(negedge clk);
    s_data_v[0] = 8'h33;
    @(negedge clk);
    s_valid_v[0] = 1'b0;
    wait_start(0, 20, waited);
    check_eq("rst_mid_started", 32'(txd_v[0]), 32'd0);
    repeat (35) @(negedge clk);
    check_eq("rst_mid_queued", 32'(cnt_v[0]), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_txd", 32'(txd_v[0]), 32'd1);
    check_eq("rst_mid_busy", 32'(busy_v[0]), 32'd0);
    check_eq("rst_mid_count", 32'(cnt_v[0]), 32'd0);
    check_eq("rst_mid_ready", 32'(ready_v[0]), 32'd1);
    check_eq("rst_mid_done", 32'(done_v[0]), 32'd0);
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (txd_v[0] !== 1'b1 || done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
    end
    check_eq("rst_mid_quiet", bad, 0);
    frame_test("after_rst_a5", 0, 8'hA5, 10, 12'h34A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
